lsu_bus_ctrl: RTL and testbench
===============================

Name: lsu_bus_ctrl

Overview:
Load/store bus sequencer sitting directly downstream of the store-data lane replication stage.
- Accepts one memory op per handshake. Store data arrives already lane-replicated; the block adds byte enables, drives a single-outstanding request/grant/rvalid memory bus, extracts and extends load data, and returns one response per op.
- Includes a watchdog timeout on the bus response.

Parameters:
- TIMEOUT_CYCLES, 255: max cycles in WAIT before an error response is forced; 0 disables the timeout.
- CNT_W, 8: width of the timeout counter; must satisfy TIMEOUT_CYCLES < 2**CNT_W.

Ports:
- clk  in  1  sole clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  op request
- req_ready  out  1  block can accept an op (high only in IDLE)
- req_we  in  1  1=store, 0=load
- req_size  in  2  0=byte, 1=half, 2=word, 3=illegal
- req_unsigned  in  1  load zero-extends when 1, sign-extends when 0
- req_addr  in  32  byte address
- req_wdata  in  32  lane-replicated store data
- mem_req  out  1  bus request
- mem_gnt  in  1  bus accepted request this cycle
- mem_addr  out  32  word address {req_addr[31:2],2'b00}
- mem_we  out  1  write strobe
- mem_be  out  4  byte enables
- mem_wdata  out  32  store data
- mem_rvalid  in  1  bus response/ack
- mem_rdata  in  32  bus read word
- resp_valid  out  1  response available
- resp_ready  in  1  consumer takes response
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_err  out  1  illegal size, misalignment (see feature) or timeout

Behaviour:
- Reset: state IDLE; req_ready=1; mem_req=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0; resp_valid=0, resp_rdata=0, resp_err=0; timeout counter 0.
- Reset mid-operation aborts the op. No response is ever produced for an aborted op. A late mem_rvalid arriving in IDLE is ignored.
- State IDLE:
  - On req_valid&req_ready, register addr/size/we/unsigned/wdata.
  - Compute mem_be:
    - size0: 4'b0001<<addr[1:0]
    - size1: addr[1]?4'b1100:4'b0011
    - size2: 4'b1111
  - Size 3 goes to RESP with resp_err=1 and never touches the bus.
  - Otherwise go to REQ.
- State REQ:
  - mem_req=1, with all mem_* outputs stable while waiting.
  - On mem_gnt go to WAIT next cycle. mem_req drops the cycle after gnt.
- State WAIT:
  - Counter increments each cycle.
  - On mem_rvalid, capture data and go to RESP.
  - If counter reaches TIMEOUT_CYCLES without rvalid, go to RESP with resp_err=1.
  - rvalid and timeout in the same cycle: rvalid wins, no error.
  - Counter clears on leaving WAIT.
- State RESP:
  - resp_valid=1, with resp_rdata/resp_err held stable until resp_ready.
  - On resp_ready go to IDLE; req_ready rises the next cycle.
- Minimum latency: accept at cycle 0, REQ at 1, gnt at 1, WAIT at 2, rvalid at 2, resp_valid at 3.
- Load extraction:
  - byte lane = addr[1:0]; half lane = addr[1].
  - Extend to 32 bits per req_unsigned.
  - Word loads pass mem_rdata through unchanged.
- mem_rvalid in REQ or RESP is a protocol error and is ignored.

Optional Feature:
MISALIGN_TRAP_EN
- Defined: a half access with addr[0]=1, or a word access with addr[1:0]!=0, goes IDLE->RESP with resp_err=1 and no bus activity.
- Undefined: the offending low address bits are ignored. Half uses addr[1] only; word uses full 4'b1111 at the word address.

Decomposition:
- Package lsu_pkg holds:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD/SZ_ILL
  - state enum IDLE/REQ/WAIT/RESP
  - function be_from_size(size,addr_lo)
- Sub-module lsu_load_extract (purely combinational): rdata, size, addr_lo, unsigned -> 32-bit result. It is the mirror of the store replication stage.

Test Plan:
- Load byte, addr=0x1003, signed, mem_rdata=0x80_11_22_33 -> mem_be=4'b1000, mem_addr=0x1000, resp_rdata=0xFFFFFF80, resp_err=0.
- Store half, addr=0x2002, wdata=0xBEEFBEEF -> mem_we=1, mem_be=4'b1100, mem_wdata=0xBEEFBEEF; resp_rdata=0 after rvalid.
- gnt held low 5 cycles, then resp_ready held low 3 cycles -> mem_req and all mem_* stable throughout; resp_valid and resp_rdata stable; req_ready=0 until handshake.
- TIMEOUT_CYCLES=4 with no rvalid -> resp_err=1 exactly 4 cycles after entering WAIT; a later rvalid in IDLE is ignored.
- size=3 -> resp_err=1 at cycle 1 with mem_req never asserted. Word load at addr=0x3001 -> resp_err=1 with MISALIGN_TRAP_EN defined; mem_be=4'b1111 at 0x3000 without it.
- Assert rst while in WAIT -> all outputs return to reset values asynchronously; the next op completes normally.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared encodings and helpers for the load/store bus sequencer.
package lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;
  localparam logic [1:0] SZ_ILL  = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_e;

  function automatic logic [3:0] be_from_size(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      SZ_BYTE: return 4'b0001 << addr_lo;
      SZ_HALF: return addr_lo[1] ? 4'b1100 : 4'b0011;
      SZ_WORD: return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    return ((size == SZ_HALF) && addr_lo[0]) || ((size == SZ_WORD) && (addr_lo != 2'b00));
  endfunction

endpackage

// File: rtl/lsu_load_extract.sv
// Picks the addressed byte/half out of a bus read word and sign/zero extends it;
// the inverse of the upstream store-data lane replication.
module lsu_load_extract (
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_size,
  input  logic [1:0]  i_addr_lo,
  input  logic        i_unsigned,
  output logic [31:0] o_data
);
  import lsu_pkg::*;

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // NOTE: every signal gets a default before the case so no path leaves it unassigned and infers a latch.
  always_comb begin
    w_byte = 8'h00;
    w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
    o_data = 32'h0000_0000;
    case (i_addr_lo)
      2'd0: w_byte = i_rdata[7:0];
      2'd1: w_byte = i_rdata[15:8];
      2'd2: w_byte = i_rdata[23:16];
      2'd3: w_byte = i_rdata[31:24];
      default: w_byte = 8'h00;
    endcase
    case (i_size)
      SZ_BYTE: o_data = {{24{w_byte[7] & ~i_unsigned}}, w_byte};
      SZ_HALF: o_data = {{16{w_half[15] & ~i_unsigned}}, w_half};
      SZ_WORD: o_data = i_rdata;
      default: o_data = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/lsu_bus_ctrl.sv
// Single-outstanding load/store bus sequencer with response watchdog.
// Define MISALIGN_TRAP_EN to reject misaligned half/word accesses without touching the bus.
module lsu_bus_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        mem_req,
  input  logic        mem_gnt,
  output logic [31:0] mem_addr,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);
  import lsu_pkg::*;

  localparam logic             LP_TO_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] LP_TIMEOUT = CNT_W'(TIMEOUT_CYCLES);

  state_e             r_state;
  logic [31:0]        r_addr;
  logic [1:0]         r_size;
  logic               r_we;
  logic               r_unsigned;
  logic [31:0]        r_wdata;
  logic [3:0]         r_be;
  logic [CNT_W-1:0]   r_cnt;
  logic [31:0]        r_resp_rdata;
  logic               r_resp_err;

  logic               w_misalign;
  logic               w_reject;
  logic [CNT_W-1:0]   w_cnt_inc;
  logic               w_timeout;
  logic [31:0]        w_load_data;

`ifdef MISALIGN_TRAP_EN
  assign w_misalign = is_misaligned(req_size, req_addr[1:0]);
`else
  assign w_misalign = 1'b0;
`endif

  assign w_reject  = (req_size == SZ_ILL) || w_misalign;
  assign w_cnt_inc = r_cnt + CNT_W'(1);
  // Timeout fires on the cycle whose increment would reach the limit, so WAIT lasts exactly TIMEOUT_CYCLES.
  assign w_timeout = LP_TO_EN && (w_cnt_inc == LP_TIMEOUT);

  lsu_load_extract u_extract (
    .i_rdata    (mem_rdata),
    .i_size     (r_size),
    .i_addr_lo  (r_addr[1:0]),
    .i_unsigned (r_unsigned),
    .o_data     (w_load_data)
  );

  // NOTE: non-blocking assignments so every register samples the pre-edge values of the others.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_addr       <= 32'h0;
      r_size       <= SZ_BYTE;
      r_we         <= 1'b0;
      r_unsigned   <= 1'b0;
      r_wdata      <= 32'h0;
      r_be         <= 4'h0;
      r_cnt        <= '0;
      r_resp_rdata <= 32'h0;
      r_resp_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_addr     <= req_addr;
            r_size     <= req_size;
            r_we       <= req_we;
            r_unsigned <= req_unsigned;
            r_wdata    <= req_wdata;
            r_be       <= be_from_size(req_size, req_addr[1:0]);
            if (w_reject) begin
              r_state      <= RESP;
              r_resp_err   <= 1'b1;
              r_resp_rdata <= 32'h0;
            end else begin
              r_state <= REQ;
            end
          end
        end
        REQ: begin
          if (mem_gnt) r_state <= WAIT;
        end
        WAIT: begin
          // A response arriving on the timeout cycle still wins.
          if (mem_rvalid) begin
            r_state      <= RESP;
            r_cnt        <= '0;
            r_resp_err   <= 1'b0;
            r_resp_rdata <= r_we ? 32'h0 : w_load_data;
          end else if (w_timeout) begin
            r_state      <= RESP;
            r_cnt        <= '0;
            r_resp_err   <= 1'b1;
            r_resp_rdata <= 32'h0;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        RESP: begin
          if (resp_ready) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign req_ready  = (r_state == IDLE);
  assign mem_req    = (r_state == REQ);
  assign mem_addr   = {r_addr[31:2], 2'b00};
  assign mem_we     = mem_req & r_we;
  assign mem_be     = mem_req ? r_be : 4'h0;
  assign mem_wdata  = r_wdata;
  assign resp_valid = (r_state == RESP);
  assign resp_rdata = r_resp_rdata;
  assign resp_err   = r_resp_err;

endmodule

// File: tb/tb_lsu_bus_ctrl.sv
// Randomized self-checking bench for lsu_bus_ctrl against a behavioural op model.
module tb_lsu_bus_ctrl;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        mem_req, mem_gnt, mem_we, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  lsu_bus_ctrl #(.TIMEOUT_CYCLES(TO), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  // ---------------- reference model ----------------
  function automatic logic [3:0] m_be(input logic [1:0] size, input logic [31:0] addr);
    int lo;
    lo = int'(addr[1:0]);
    case (size)
      2'd0:    return 4'(1 << lo);
      2'd1:    return 4'(3 << (2 * int'(addr[1])));
      default: return 4'hF;
    endcase
  endfunction

  function automatic logic [31:0] m_load(input logic [1:0] size, input logic [31:0] addr,
                                         input logic uns, input logic [31:0] rdata);
    logic [31:0] v;
    int sh;
    if (size == 2'd2) return rdata;
    sh = (size == 2'd0) ? 8 * int'(addr[1:0]) : 16 * int'(addr[1]);
    v  = rdata >> sh;
    if (size == 2'd0) begin
      v = v & 32'h0000_00FF;
      if (!uns && v[7]) v = v | 32'hFFFF_FF00;
    end else begin
      v = v & 32'h0000_FFFF;
      if (!uns && v[15]) v = v | 32'hFFFF_0000;
    end
    return v;
  endfunction

  function automatic bit m_trap(input logic [1:0] size, input logic [31:0] addr);
    if (size == 2'd3) return 1'b1;
`ifdef MISALIGN_TRAP_EN
    if (size == 2'd1 && addr[0]) return 1'b1;
    if (size == 2'd2 && addr[1:0] != 2'b00) return 1'b1;
`endif
    return 1'b0;
  endfunction

  // ---------------- one complete op with inline checks ----------------
  task automatic run_op(input string tag, input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] rdata,
                        input int gnt_dly, input int rv_dly, input int rdy_dly);
    logic [69:0] exp_bus;
    logic [31:0] exp_rd;
    logic        exp_err;
    logic        trap;
    trap    = m_trap(size, addr);
    exp_bus = {1'b1, we, m_be(size, addr), addr[31:2], 2'b00, wdata};
    exp_rd  = 32'h0;
    exp_err = 1'b1;

    n_cmp++;
    if (req_ready !== 1'b1) begin
      n_bad++; $display("FAIL %s accept_ready: got %b want 1", tag, req_ready);
    end
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    @(negedge clk);
    req_valid = 1'b0; req_we = $urandom; req_size = 2'($urandom);
    req_unsigned = $urandom; req_addr = $urandom; req_wdata = $urandom;

    if (trap) begin
      n_cmp++;
      if (mem_req !== 1'b0) begin
        n_bad++; $display("FAIL %s trap_no_bus: got mem_req=%b want 0", tag, mem_req);
      end
    end else begin
      for (int c = 0; c <= gnt_dly; c++) begin
        n_cmp++;
        if ({req_ready, resp_valid, mem_req, mem_we, mem_be, mem_addr, mem_wdata} !== {2'b00, exp_bus}) begin
          n_bad++;
          $display("FAIL %s req_bus c=%0d: got rdy=%b rv=%b req=%b we=%b be=%b addr=%h wd=%h want req=1 we=%b be=%b addr=%h wd=%h",
                   tag, c, req_ready, resp_valid, mem_req, mem_we, mem_be, mem_addr, mem_wdata,
                   we, m_be(size, addr), {addr[31:2], 2'b00}, wdata);
        end
        mem_gnt    = (c == gnt_dly);
        mem_rvalid = (c != gnt_dly) && ($urandom_range(0, 3) == 0);
        mem_rdata  = $urandom;
        @(negedge clk);
      end
      mem_gnt = 1'b0; mem_rvalid = 1'b0;
      for (int k = 0; k < TO; k++) begin
        n_cmp++;
        if ({mem_req, resp_valid, req_ready} !== 3'b000) begin
          n_bad++; $display("FAIL %s wait k=%0d: got req=%b resp_valid=%b rdy=%b want 000", tag, k, mem_req, resp_valid, req_ready);
        end
        if (k == rv_dly) begin
          mem_rvalid = 1'b1; mem_rdata = rdata;
          exp_err = 1'b0;
          exp_rd  = we ? 32'h0 : m_load(size, addr, uns, rdata);
          @(negedge clk);
          mem_rvalid = 1'b0; mem_rdata = $urandom;
          break;
        end
        @(negedge clk);
      end
    end

    for (int c = 0; c <= rdy_dly; c++) begin
      n_cmp++;
      if ({resp_valid, resp_err, resp_rdata, req_ready, mem_req} !== {1'b1, exp_err, exp_rd, 2'b00}) begin
        n_bad++;
        $display("FAIL %s resp c=%0d: got valid=%b err=%b rdata=%h rdy=%b req=%b want valid=1 err=%b rdata=%h",
                 tag, c, resp_valid, resp_err, resp_rdata, req_ready, mem_req, exp_err, exp_rd);
      end
      resp_ready = (c == rdy_dly);
      mem_rvalid = (c != rdy_dly) && ($urandom_range(0, 3) == 0);
      mem_rdata  = $urandom;
      @(negedge clk);
    end
    resp_ready = 1'b0; mem_rvalid = 1'b0;
    n_cmp++;
    if ({req_ready, resp_valid} !== 2'b10) begin
      n_bad++; $display("FAIL %s after_handshake: got rdy=%b valid=%b want 1 0", tag, req_ready, resp_valid);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({req_ready, mem_req, mem_we, mem_be, mem_addr, mem_wdata, resp_valid, resp_rdata, resp_err} !== {1'b1, 104'b0}) begin
      n_bad++;
      $display("FAIL reset_values: got rdy=%b req=%b we=%b be=%b addr=%h wd=%h valid=%b rdata=%h err=%b want 1 then zeros",
               req_ready, mem_req, mem_we, mem_be, mem_addr, mem_wdata, resp_valid, resp_rdata, resp_err);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_directed;
    run_op("load_byte_signed", 1'b0, 2'd0, 1'b0, 32'h0000_1003, 32'h0, 32'h8011_2233, 0, 0, 0);
    run_op("store_half", 1'b1, 2'd1, 1'b0, 32'h0000_2002, 32'hBEEF_BEEF, 32'h1234_5678, 0, 0, 0);
    run_op("stall_gnt_ready", 1'b0, 2'd1, 1'b1, 32'h0000_0106, 32'h0, 32'hF00D_8001, 5, 1, 3);
    run_op("illegal_size", 1'b0, 2'd3, 1'b0, 32'h0000_0040, 32'h0, 32'h0, 0, 0, 0);
    run_op("word_misaligned", 1'b0, 2'd2, 1'b0, 32'h0000_3001, 32'h0, 32'hCAFE_F00D, 0, 2, 0);
    run_op("half_odd", 1'b0, 2'd1, 1'b0, 32'h0000_3003, 32'h0, 32'h9ABC_1234, 1, 0, 1);
  endtask

  task automatic test_timeout;
    run_op("timeout", 1'b0, 2'd2, 1'b0, 32'h0000_5000, 32'h0, 32'h0, 0, TO, 1);
    for (int c = 0; c < 3; c++) begin
      mem_rvalid = (c == 0); mem_rdata = 32'hDEAD_BEEF;
      @(negedge clk);
      n_cmp++;
      if ({req_ready, resp_valid, mem_req} !== 3'b100) begin
        n_bad++; $display("FAIL late_rvalid c=%0d: got rdy=%b valid=%b req=%b want 1 0 0", c, req_ready, resp_valid, mem_req);
      end
    end
    mem_rvalid = 1'b0;
    run_op("rvalid_on_limit", 1'b0, 2'd0, 1'b1, 32'h0000_5002, 32'h0, 32'h00C3_0000, 0, TO - 1, 0);
  endtask

  task automatic test_reset_mid;
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_unsigned = 1'b0;
    req_addr = 32'h0000_4440; req_wdata = 32'hA5A5_5A5A;
    @(negedge clk);
    req_valid = 1'b0; mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({req_ready, mem_req, mem_we, mem_be, mem_addr, mem_wdata, resp_valid, resp_rdata, resp_err} !== {1'b1, 104'b0}) begin
      n_bad++;
      $display("FAIL async_reset_mid: got rdy=%b req=%b we=%b be=%b addr=%h wd=%h valid=%b rdata=%h err=%b want 1 then zeros",
               req_ready, mem_req, mem_we, mem_be, mem_addr, mem_wdata, resp_valid, resp_rdata, resp_err);
    end
    @(negedge clk);
    rst = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'h1111_2222;
    @(negedge clk);
    mem_rvalid = 1'b0;
    n_cmp++;
    if ({req_ready, resp_valid} !== 2'b10) begin
      n_bad++; $display("FAIL aborted_no_resp: got rdy=%b valid=%b want 1 0", req_ready, resp_valid);
    end
    run_op("after_reset", 1'b0, 2'd0, 1'b0, 32'h0000_4441, 32'h0, 32'h0000_7F00, 0, 0, 0);
  endtask

  task automatic test_random;
    logic        we, uns;
    logic [1:0]  size;
    logic [31:0] addr, w, wdata;
    for (int i = 0; i < 60; i++) begin
      we   = $urandom;
      uns  = $urandom;
      size = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      addr = $urandom;
      w    = $urandom;
      wdata = (size == 2'd0) ? {4{w[7:0]}} : (size == 2'd1) ? {2{w[15:0]}} : w;
      run_op("random", we, size, uns, addr, wdata, $urandom,
             $urandom_range(0, 3), $urandom_range(0, TO + 1), $urandom_range(0, 2));
    end
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
    mem_rdata = 32'h0; resp_ready = 1'b0;
    test_reset();
    test_directed();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
